// File: rtl/priority_encoder_rr.sv
// ============================================================================
// priority_encoder_rr : N-input fixed/round-robin priority encoder, registered
// Revision: 1.0
// ============================================================================
`default_nettype none

module priority_encoder_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot
);

  logic         out_valid_q,  out_valid_d;
  logic [W-1:0] out_idx_q,    out_idx_d;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic [W-1:0] ptr_q,        ptr_d;

  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;
  logic         any_req;
  logic         slot_free;
  int           rr_best;
  int           ptr_int;

  // Distance of candidate i behind the pointer; the pointer itself is farthest.
  function automatic int rr_dist(input int i, input int p);
    return (i < p) ? (p - i) : (p - i + N);
  endfunction

  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fix_idx = W'(i);
    end
  end

  always_comb begin
    rr_idx  = '0;
    rr_best = N + 1;
    ptr_int = int'(ptr_q);
    for (int i = 0; i < N; i++) begin
      if (req[i] && (rr_dist(i, ptr_int) < rr_best)) begin
        rr_best = rr_dist(i, ptr_int);
        rr_idx  = W'(i);
      end
    end
  end

  assign any_req   = |req;
  assign win_idx   = mode ? rr_idx : fix_idx;
  assign slot_free = ~out_valid_q | out_ready;

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < N; i++) begin
      win_onehot[i] = (win_idx == W'(i));
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    ptr_d        = ptr_q;
    if (slot_free) begin
      if (any_req) begin
        out_valid_d  = 1'b1;
        out_idx_d    = win_idx;
        out_onehot_d = win_onehot;
        ptr_d        = win_idx;
      end else begin
        // Idle cycle: outputs clear but the fairness pointer is kept.
        out_valid_d  = 1'b0;
        out_idx_d    = '0;
        out_onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      ptr_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      ptr_q        <= ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_rr.sv
// ============================================================================
// tb_priority_encoder_rr : scoreboard bench for N=8 and N=5 encoders
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_priority_encoder_rr;

  typedef struct {
    logic        valid;
    int          idx;
    logic [63:0] onehot;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req8;
  logic [4:0] req5;
  logic       mode;
  logic       ready;

  logic       v8, v5;
  logic [2:0] idx8, idx5;
  logic [7:0] oh8;
  logic [4:0] oh5;

  int n_cmp = 0;
  int n_err = 0;

  exp_t q8[$];
  exp_t q5[$];

  int m8v = 0, m8i = 0, m8p = 0;
  int m5v = 0, m5i = 0, m5p = 0;

  priority_encoder_rr #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode), .out_ready(ready),
    .out_valid(v8), .out_idx(idx8), .out_onehot(oh8)
  );

  priority_encoder_rr #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode), .out_ready(ready),
    .out_valid(v5), .out_idx(idx5), .out_onehot(oh5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: walk the search order of the active mode and take the first request.
  function automatic int winner(input int n, input logic [63:0] r, input logic md, input int p);
    if (!md) begin
      for (int i = n - 1; i >= 0; i--)
        if (((r >> i) & 64'd1) != 64'd0) return i;
    end else begin
      for (int k = 1; k <= n; k++) begin
        int c;
        c = (p - k + n) % n;
        if (((r >> c) & 64'd1) != 64'd0) return c;
      end
    end
    return -1;
  endfunction

  task automatic step(input int n, input logic [63:0] r, input logic md, input logic rdy,
                      inout int v, inout int ix, inout int p, output exp_t e);
    int w;
    if (v == 0 || rdy) begin
      w = winner(n, r, md, p);
      if (w >= 0) begin
        v = 1; ix = w; p = w;
      end else begin
        v = 0; ix = 0;
      end
    end
    e.valid  = (v != 0);
    e.idx    = ix;
    e.onehot = (v != 0) ? (64'd1 << ix) : 64'd0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one expected entry per clock edge, queue flushed by reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m8v = 0; m8i = 0; m8p = 0;
        m5v = 0; m5i = 0; m5p = 0;
        q8.delete();
        q5.delete();
      end else begin
        step(8, 64'(req8), mode, ready, m8v, m8i, m8p, e);
        q8.push_back(e);
        step(5, 64'(req5), mode, ready, m5v, m5i, m5p, e);
        q5.push_back(e);
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("sb8.valid",  64'(v8),   64'(e.valid));
        chk("sb8.idx",    64'(idx8), 64'(e.idx));
        chk("sb8.onehot", 64'(oh8),  e.onehot);
      end
      if (q5.size() > 0) begin
        e = q5.pop_front();
        chk("sb5.valid",  64'(v5),   64'(e.valid));
        chk("sb5.idx",    64'(idx5), 64'(e.idx));
        chk("sb5.onehot", 64'(oh5),  e.onehot);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic d8(input string name, input logic v, input int ix);
    chk({name, ".valid"},  64'(v8),   64'(v));
    chk({name, ".idx"},    64'(idx8), 64'(ix));
    chk({name, ".onehot"}, 64'(oh8),  v ? (64'd1 << ix) : 64'd0);
  endtask

  task automatic d5(input string name, input logic v, input int ix);
    chk({name, ".valid"},  64'(v5),   64'(v));
    chk({name, ".idx"},    64'(idx5), 64'(ix));
    chk({name, ".onehot"}, 64'(oh5),  v ? (64'd1 << ix) : 64'd0);
  endtask

  initial begin
    int sweep[9];
    int fair8[4];
    int fair5[3];
    sweep = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    fair8 = '{7, 0, 7, 0};
    fair5 = '{4, 0, 4};

    rst_n = 1'b0; req8 = '0; req5 = '0; mode = 1'b0; ready = 1'b0;
    cyc(); cyc();
    d8("reset8", 1'b0, 0);
    d5("reset5", 1'b0, 0);
    rst_n = 1'b1;

    // Fixed priority
    mode = 1'b0; ready = 1'b1; req8 = 8'b0010_1100;
    cyc();
    d8("fixed", 1'b1, 5);

    // Backpressure hold, then accept with a new request on the same edge
    ready = 1'b0; req8 = 8'h80;
    for (int i = 0; i < 3; i++) begin
      cyc();
      d8("hold", 1'b1, 5);
    end
    ready = 1'b1;
    cyc();
    d8("accept_reload", 1'b1, 7);

    // Asynchronous reset while holding
    ready = 1'b0;
    cyc();
    d8("hold_pre_reset", 1'b1, 7);
    rst_n = 1'b0;
    #1;
    d8("async_reset", 1'b0, 0);
    req8 = '0;
    cyc();
    rst_n = 1'b1;

    // Round-robin sweep from reset
    mode = 1'b1; ready = 1'b1; req8 = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cyc();
      d8($sformatf("rr_sweep%0d", i), 1'b1, sweep[i]);
    end

    // Fairness from reset, N=8 and N=5
    rst_n = 1'b0; req8 = '0;
    cyc();
    rst_n = 1'b1; req8 = 8'b1000_0001; req5 = 5'b1_0001;
    for (int i = 0; i < 4; i++) begin
      cyc();
      d8($sformatf("rr_fair8_%0d", i), 1'b1, fair8[i]);
      if (i < 3) d5($sformatf("rr_fair5_%0d", i), 1'b1, fair5[i]);
    end
    mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      d8($sformatf("fixed_fair%0d", i), 1'b1, 7);
    end

    // Idle
    req8 = '0; req5 = '0;
    cyc();
    d8("idle8", 1'b0, 0);
    d5("idle5", 1'b0, 0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      req8  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      req5  = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      ready = ($urandom_range(0, 2) != 0);
      cyc();
      chk("idx5_range", 64'(idx5 > 3'd4), 64'd0);
    end

    rst_n = 1'b1; req8 = '0; req5 = '0;
    cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/priority_encoder_rr.md
Name: priority_encoder_rr

Overview:
- Parametrised N-input priority encoder with registered outputs.
- Selectable fixed-priority or round-robin mode.
- valid/ready output handshake.
- Generalises the 4:2 combinational encoder (highest index wins, valid flag) to arbitrary width, adds a round-robin fairness mode, and holds the result under backpressure. Sits between request sources and a downstream consumer such as a display, mux select or FSM.

Parameters:
- N, 8, number of request inputs; legal range 2..64.
- W, $clog2(N), width of encoded index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i is request i.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- out_ready  input  1  consumer accepts the current result this cycle.
- out_valid  output  1  registered result is valid (any request was captured).
- out_idx  output  W  encoded index of the winning request.
- out_onehot  output  N  one-hot of the winning request.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): out_valid=0, out_idx=0, out_onehot=0, internal pointer ptr=0.
  - Takes effect mid-hold; a pending result is discarded.
- Slot free when out_valid=0 or out_ready=1. All state changes only on a rising clk with a free slot.
- Slot free and req!=0:
  - Load winner into out_idx and out_onehot.
  - out_valid=1.
  - ptr <= winner.
  - Latency: 1 cycle from req to out_valid.
- Slot free and req==0: out_valid=0, out_onehot=0, out_idx=0; ptr unchanged.
- Slot not free (out_valid=1, out_ready=0): all outputs and ptr hold; req changes are ignored and not queued.
- Simultaneous accept and new request: the same edge retires the old result and loads the new one, giving back-to-back throughput of 1 per cycle.
- Fixed mode (mode=0): winner = highest set bit of req (bit N-1 has top priority).
- Round-robin mode (mode=1): search order ptr-1, ptr-2, …, 0, N-1, …, ptr, modulo N; the first set bit wins.
  - With ptr=0, order starts at N-1, so the first grant after reset equals fixed mode.
  - The last winner gets lowest priority next time.
- ptr updates on every load in both modes. A mode change takes effect at the next load; no other state is reset.
- N not a power of two: index arithmetic is modulo N; out_idx never exceeds N-1.
- out_onehot always has exactly one bit set when out_valid=1, and equals 1<<out_idx.
- Fully synchronous apart from reset; no combinational path from req to outputs.

Test Plan (N=8 unless stated):
1. Reset: drive rst_n=0 mid-operation while out_valid=1 and out_ready=0 -> out_valid, out_idx and out_onehot go to 0 immediately without waiting for clk. After release, ptr=0 is verified by test 4's first grant of 7.
2. Fixed mode: mode=0, out_ready=1, req=8'b0010_1100 -> next cycle out_valid=1, out_idx=5, out_onehot=8'b0010_0000.
3. Backpressure: hold idx 5 with out_ready=0 while req changes to 8'h80 for 3 cycles -> outputs stay at idx 5. Then set out_ready=1 -> the next edge loads out_idx=7, out_onehot=8'h80.
4. Round-robin sweep: from reset, mode=1, req=8'hFF held, out_ready=1 -> successive out_idx 7,6,5,4,3,2,1,0,7.
5. Round-robin fairness: from reset, mode=1, req=8'b1000_0001 held, out_ready=1 -> out_idx alternates 7,0,7,0. The same stimulus with mode=0 -> out_idx=7 every cycle.
6. Idle and non-power-of-two: req=0 with out_ready=1 -> out_valid=0 and out_onehot=0 next cycle.
   - With N=5 and mode=1, req=5'b1_0001 from reset -> out_idx 4,0,4, with out_idx never above 4.
